// File: rtl/spi_sram_pkg.sv
// Shared command codes, FSM encoding and frame-length helper for the SPI SRAM master.
package spi_sram_pkg;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CMD  = 3'd1,
    ADDR = 3'd2,
    DATA = 3'd3,
    GAP  = 3'd4,
    DONE = 3'd5
  } state_e;

  // Total serial bits per frame: command byte, address, data bytes.
  function automatic int unsigned calc_nbits(input int unsigned addr_width,
                                             input int unsigned data_bytes);
    return 8 + addr_width + 8 * data_bytes;
  endfunction

endpackage

// File: rtl/spi_sram_sclk_gen.sv
// SPI mode-0 clock divider: sclk idles low, toggles every CLK_DIV cycles while enabled.
module spi_sram_sclk_gen #(
  parameter int unsigned CLK_DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  output logic o_sclk,
  output logic o_rise,
  output logic o_fall
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic          r_sclk;
  logic          w_wrap;

  // Strobes announce the edge at which sclk changes, so users act on the same clk edge.
  assign w_wrap = i_en && (r_cnt == CW'(CLK_DIV - 1));
  assign o_rise = w_wrap && !r_sclk;
  assign o_fall = w_wrap && r_sclk;
  assign o_sclk = r_sclk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
    end else if (!i_en) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
    end else if (w_wrap) begin
      r_cnt  <= '0;
      r_sclk <= ~r_sclk;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_sram_master.sv
// SPI mode-0 master for a 23LC-class serial SRAM: READ/WRITE bursts with parametrised geometry.
module spi_sram_master
  import spi_sram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 24,
  parameter int unsigned DATA_BYTES = 1,
  parameter int unsigned CLK_DIV    = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_start,
  input  logic                    i_write,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  input  logic [8*DATA_BYTES-1:0] i_wdata,
  output logic [8*DATA_BYTES-1:0] o_rdata,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    sram_cs,
  output logic                    sram_sclk,
  output logic                    sram_mosi,
  input  logic                    sram_miso
);

  localparam int unsigned N   = calc_nbits(ADDR_WIDTH, DATA_BYTES);
  localparam int unsigned DW  = 8 * DATA_BYTES;
  localparam int unsigned BCW = $clog2(N + 1);
  localparam int unsigned GW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  state_e          r_state;
  logic            r_write;
  logic [N-1:0]    r_shift;
  logic [BCW-1:0]  r_bit_cnt;
  logic [GW-1:0]   r_gap_cnt;
  logic [DW-1:0]   r_rx;
  logic [DW-1:0]   r_rdata;
  logic [BCW-1:0]  w_bit_nxt;
  logic            w_active;
  logic            w_rise;
  logic            w_fall;
  logic [DW-1:0]   w_wdata_ser;
  logic [DW-1:0]   w_rx_par;

  assign w_active  = (r_state == CMD) || (r_state == ADDR) || (r_state == DATA);
  assign w_bit_nxt = r_bit_cnt + 1'b1;

  // Byte j sits at bits [8j+7:8j] but goes on the wire j-th, so serial order is byte-reversed.
  always_comb begin
    w_wdata_ser = '0;
    w_rx_par    = '0;
    for (int unsigned j = 0; j < DATA_BYTES; j++) begin
      w_wdata_ser[8*(DATA_BYTES-1-j) +: 8] = i_wdata[8*j +: 8];
      w_rx_par[8*j +: 8]                   = r_rx[8*(DATA_BYTES-1-j) +: 8];
    end
  end

  spi_sram_sclk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sclk_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_active),
    .o_sclk(sram_sclk),
    .o_rise(w_rise),
    .o_fall(w_fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_write   <= 1'b0;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_gap_cnt <= '0;
      r_rx      <= '0;
      r_rdata   <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (i_start) begin
            r_state   <= CMD;
            r_write   <= i_write;
            r_bit_cnt <= '0;
            // Read frames carry zeros in the data slot, which keeps MOSI low during DATA.
            r_shift   <= {(i_write ? CMD_WRITE : CMD_READ), i_addr,
                          (i_write ? w_wdata_ser : {DW{1'b0}})};
          end
        end
        CMD, ADDR, DATA: begin
          if (w_rise && (r_state == DATA) && !r_write) begin
            r_rx <= {r_rx[DW-2:0], sram_miso};
          end
          if (w_fall) begin
            r_shift   <= {r_shift[N-2:0], 1'b0};
            r_bit_cnt <= w_bit_nxt;
            if (w_bit_nxt == BCW'(N)) begin
              r_state   <= GAP;
              r_gap_cnt <= '0;
            end else if (w_bit_nxt == BCW'(8 + ADDR_WIDTH)) begin
              r_state <= DATA;
            end else if (w_bit_nxt == BCW'(8)) begin
              r_state <= ADDR;
            end
          end
        end
        GAP: begin
          if (r_gap_cnt == GW'(CLK_DIV - 1)) begin
            r_state <= DONE;
            if (!r_write) r_rdata <= w_rx_par;
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign sram_cs   = ~w_active;
  assign sram_mosi = r_shift[N-1];
  assign o_busy    = (r_state != IDLE) && (r_state != DONE);
  assign o_done    = (r_state == DONE);
  assign o_rdata   = r_rdata;

endmodule

// File: tb/tb_spi_sram_master.sv
// Scoreboard bench: expected MOSI bits and read data queued at start, popped as the frame runs.
module tb_spi_sram_master;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        s0, w0, busy0, done0, cs0, sclk0, mosi0;
  logic [23:0] a0;
  logic [7:0]  wd0, rd0;
  logic        s1, w1, busy1, done1, cs1, sclk1, mosi1;
  logic [15:0] a1;
  logic [31:0] wd1, rd1;
  logic        miso = 1'b0;
  logic        sel = 1'b0;

  logic        m_cs, m_sclk, m_mosi, m_busy, m_done;
  logic [31:0] m_rdata;

  bit          exp_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] last_rd[2];
  int          nchk = 0;
  int          nerr = 0;

  spi_sram_master u_dut0 (
    .clk(clk), .rst_n(rst_n), .i_start(s0), .i_write(w0), .i_addr(a0), .i_wdata(wd0),
    .o_rdata(rd0), .o_busy(busy0), .o_done(done0), .sram_cs(cs0), .sram_sclk(sclk0),
    .sram_mosi(mosi0), .sram_miso(miso)
  );

  spi_sram_master #(.ADDR_WIDTH(16), .DATA_BYTES(4), .CLK_DIV(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .i_start(s1), .i_write(w1), .i_addr(a1), .i_wdata(wd1),
    .o_rdata(rd1), .o_busy(busy1), .o_done(done1), .sram_cs(cs1), .sram_sclk(sclk1),
    .sram_mosi(mosi1), .sram_miso(miso)
  );

  always_comb begin
    m_cs    = sel ? cs1 : cs0;
    m_sclk  = sel ? sclk1 : sclk0;
    m_mosi  = sel ? mosi1 : mosi0;
    m_busy  = sel ? busy1 : busy0;
    m_done  = sel ? done1 : done0;
    m_rdata = sel ? rd1 : {24'h0, rd0};
  end

  task automatic drive(input logic st, input logic wr, input logic [23:0] ad,
                       input logic [31:0] wd);
    if (sel) begin
      s1 = st; w1 = wr; a1 = ad[15:0]; wd1 = wd;
    end else begin
      s0 = st; w0 = wr; a0 = ad; wd0 = wd[7:0];
    end
  endtask

  // Starts at a negedge with the DUT idle; returns at the negedge of the cycle after o_done.
  task automatic run_txn(input logic wr, input logic [23:0] addr, input logic [31:0] wdata,
                         input logic [31:0] model, input int mid_at, input bit done_start,
                         input bit hold);
    int aw, db, div, n, rises, cslow, gapc, run, lat, d;
    bit prev_sclk, prev_cs, held, stab_err, run_err, gap_err, extra_err, got_done, eb;
    logic [7:0]  cmd;
    logic [31:0] exp_rd;
    aw  = sel ? 16 : 24;
    db  = sel ? 4 : 1;
    div = sel ? 2 : 1;
    n   = 8 + aw + 8 * db;
    cmd = wr ? 8'h02 : 8'h03;
    for (int i = 7; i >= 0; i--) exp_q.push_back(cmd[i]);
    for (int i = aw - 1; i >= 0; i--) exp_q.push_back(addr[i]);
    for (int j = 0; j < db; j++)
      for (int i = 7; i >= 0; i--) exp_q.push_back(wr ? wdata[8*j+i] : 1'b0);
    exp_rd = wr ? last_rd[sel] : (sel ? model : {24'h0, model[7:0]});
    rd_q.push_back(exp_rd);
    last_rd[sel] = exp_rd;

    drive(1'b1, wr, addr, wdata);
    @(negedge clk);
    drive(hold, ~wr, ~addr, ~wdata);
    rises = 0; cslow = 0; gapc = 0; run = 0; lat = 0;
    prev_sclk = 0; prev_cs = 1; held = 0;
    stab_err = 0; run_err = 0; gap_err = 0; extra_err = 0; got_done = 0;
    for (int c = 1; c <= 4000 && !got_done; c++) begin
      if (c > 1) @(negedge clk);
      if (c == mid_at) drive(1'b1, ~wr, ~addr, ~wdata);
      if (c == mid_at + 1) drive(hold, ~wr, ~addr, ~wdata);
      if (c == 1) begin
        nchk++;
        if (m_cs !== 1'b0 || m_busy !== 1'b1) begin
          nerr++;
          $display("FAIL accept: cs=%b busy=%b, want cs=0 busy=1", m_cs, m_busy);
        end
      end
      if (m_cs === 1'b0) begin
        cslow++;
        if (prev_cs) run = 1;
        else if (m_sclk === prev_sclk) run++;
        else begin
          if (run != div) run_err = 1;
          run = 1;
        end
        if (m_sclk === 1'b1 && !prev_sclk) begin
          rises++;
          if (exp_q.size() == 0) extra_err = 1;
          else begin
            eb = exp_q.pop_front();
            nchk++;
            if (m_mosi !== eb) begin
              nerr++;
              $display("FAIL mosi bit %0d: got %b want %b", rises - 1, m_mosi, eb);
            end
          end
          held = m_mosi;
        end else if (m_sclk === 1'b1 && m_mosi !== held) begin
          stab_err = 1;
        end
        if (m_sclk === 1'b0) begin
          if (rises >= 8 + aw && rises < n) begin
            d    = rises - 8 - aw;
            miso = model[8*(d/8) + 7 - (d%8)];
          end else begin
            miso = 1'b0;
          end
        end
      end else begin
        if (!prev_cs && run != div) run_err = 1;
        if (m_done === 1'b1) begin
          got_done = 1;
          lat      = c;
        end else if (c > 1) begin
          gapc++;
          if (m_sclk !== 1'b0 || m_mosi !== 1'b0 || m_busy !== 1'b1) gap_err = 1;
        end
      end
      prev_sclk = m_sclk;
      prev_cs   = m_cs;
    end

    exp_rd = rd_q.pop_front();
    nchk++;
    if (!got_done) begin
      nerr++;
      $display("FAIL timeout: no o_done within 4000 cycles");
    end else begin
      nchk++;
      if (lat != 1 + 2*div*n + div) begin
        nerr++;
        $display("FAIL latency: got %0d want %0d", lat, 1 + 2*div*n + div);
      end
      nchk++;
      if (cslow != 2*div*n) begin
        nerr++;
        $display("FAIL cs_low: got %0d want %0d", cslow, 2*div*n);
      end
      nchk++;
      if (exp_q.size() != 0 || extra_err || rises != n) begin
        nerr++;
        $display("FAIL bit_count: got %0d want %0d", rises, n);
      end
      nchk++;
      if (stab_err) begin
        nerr++;
        $display("FAIL mosi_stable: got change while sclk=1, want stable");
      end
      nchk++;
      if (run_err) begin
        nerr++;
        $display("FAIL half_period: got a run not equal to %0d cycles", div);
      end
      nchk++;
      if (gapc != div || gap_err) begin
        nerr++;
        $display("FAIL gap: got %0d cycles (err=%b) want %0d clean", gapc, gap_err, div);
      end
      nchk++;
      if (m_busy !== 1'b0) begin
        nerr++;
        $display("FAIL done_busy: got busy=%b want 0", m_busy);
      end
      nchk++;
      if (m_rdata !== exp_rd) begin
        nerr++;
        $display("FAIL rdata: got %h want %h", m_rdata, exp_rd);
      end
    end
    if (done_start) drive(1'b1, ~wr, 24'h000777, ~wdata);
    @(negedge clk);
    if (done_start) drive(1'b0, wr, addr, wdata);
    nchk++;
    if (m_done !== 1'b0 || m_busy !== 1'b0) begin
      nerr++;
      $display("FAIL done_pulse: got done=%b busy=%b want 0 0", m_done, m_busy);
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    nchk++;
    if ({cs0, sclk0, mosi0, busy0, done0} !== 5'b10000) begin
      nerr++;
      $display("FAIL reset_pins0: got %b want 10000", {cs0, sclk0, mosi0, busy0, done0});
    end
    nchk++;
    if ({cs1, sclk1, mosi1, busy1, done1} !== 5'b10000) begin
      nerr++;
      $display("FAIL reset_pins1: got %b want 10000", {cs1, sclk1, mosi1, busy1, done1});
    end
    nchk++;
    if (rd0 !== 8'h00 || rd1 !== 32'h0) begin
      nerr++;
      $display("FAIL reset_rdata: got %h/%h want 0/0", rd0, rd1);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_read_default();
    sel = 1'b0;
    run_txn(1'b0, 24'h000123, 32'h0, 32'hA5, 0, 1'b0, 1'b0);
  endtask

  task automatic test_write_default();
    sel = 1'b0;
    run_txn(1'b1, 24'hABCDEF, 32'h3C, 32'h0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_wide_burst();
    sel = 1'b1;
    run_txn(1'b0, 24'h000010, 32'h0, 32'h44332211, 0, 1'b0, 1'b0);
    run_txn(1'b1, 24'h001234, 32'hDEADBEEF, 32'h0, 0, 1'b0, 1'b0);
    sel = 1'b0;
  endtask

  task automatic test_ignore_start();
    sel = 1'b0;
    run_txn(1'b0, 24'h00ABCD, 32'h0, 32'h5A, 30, 1'b1, 1'b0);
    run_txn(1'b1, 24'h000001, 32'h81, 32'h0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    bit bad;
    sel = 1'b0;
    drive(1'b1, 1'b0, 24'h000040, 32'h0);
    @(negedge clk);
    drive(1'b0, 1'b0, 24'h0, 32'h0);
    repeat (40) @(negedge clk);
    nchk++;
    if (cs0 !== 1'b0 || busy0 !== 1'b1) begin
      nerr++;
      $display("FAIL mid_pre: got cs=%b busy=%b want 0 1", cs0, busy0);
    end
    rst_n = 1'b0;
    #1;
    nchk++;
    if ({cs0, sclk0, busy0, done0} !== 4'b1000) begin
      nerr++;
      $display("FAIL mid_reset_pins: got %b want 1000", {cs0, sclk0, busy0, done0});
    end
    nchk++;
    if (rd0 !== 8'h00 || rd1 !== 32'h0) begin
      nerr++;
      $display("FAIL mid_reset_rdata: got %h/%h want 0/0", rd0, rd1);
    end
    last_rd[0] = '0;
    last_rd[1] = '0;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (done0 !== 1'b0 || cs0 !== 1'b1) bad = 1;
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (done0 !== 1'b0 || cs0 !== 1'b1) bad = 1;
    end
    nchk++;
    if (bad) begin
      nerr++;
      $display("FAIL mid_no_done: got activity after reset, want none");
    end
    run_txn(1'b0, 24'h000077, 32'h0, 32'hC3, 0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [23:0] a;
    logic [7:0]  d;
    sel = 1'b0;
    for (int f = 0; f < 3; f++) begin
      a = 24'($urandom);
      d = 8'($urandom);
      run_txn(1'b1, a, {24'h0, d}, 32'h0, 0, 1'b0, 1'b1);
    end
    drive(1'b0, 1'b0, 24'h0, 32'h0);
    @(negedge clk);
    nchk++;
    if (busy0 !== 1'b0 || cs0 !== 1'b1) begin
      nerr++;
      $display("FAIL b2b_idle: got busy=%b cs=%b want 0 1", busy0, cs0);
    end
  endtask

  initial begin
    s0 = 0; w0 = 0; a0 = '0; wd0 = '0;
    s1 = 0; w1 = 0; a1 = '0; wd1 = '0;
    last_rd[0] = '0;
    last_rd[1] = '0;
    test_reset();
    test_read_default();
    test_write_default();
    test_wide_burst();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
